// File: rtl/ps2_game_keypad.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ps2_game_keypad
//  Description : PS/2 Set-2 receiver and decoder producing the two player
//                control vectors and the start pulse for the game logic.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_game_keypad #(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 5000
) (
   input  logic       vga_clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [4:0] p1_control,
   output logic [4:0] p2_control,
   output logic       start,
   output logic       rx_err
);

   localparam int c_filt_w = $clog2(FILTER_LEN + 1);
   localparam int c_tmo_w  = $clog2(TIMEOUT_CYC + 1);
   localparam logic [c_filt_w-1:0] c_filt_last = c_filt_w'(FILTER_LEN - 1);
   localparam logic [c_tmo_w-1:0]  c_tmo_last  = c_tmo_w'(TIMEOUT_CYC - 1);

   localparam logic [1:0] c_idle   = 2'd0;
   localparam logic [1:0] c_data   = 2'd1;
   localparam logic [1:0] c_parity = 2'd2;
   localparam logic [1:0] c_stop   = 2'd3;

   logic                r_clk_meta, r_clk_sync, r_dat_meta, r_dat_sync;
   logic                r_clk_filt, r_clk_filt_d;
   logic [c_filt_w-1:0] r_filt_cnt;
   logic [1:0]          r_state;
   logic [7:0]          r_shift;
   logic [2:0]          r_bit_cnt;
   logic                r_parity;
   logic [c_tmo_w-1:0]  r_tmo_cnt;
   logic                r_byte_valid;
   logic [7:0]          r_byte;
   logic                r_rx_err;
   logic                r_ext, r_brk;
   logic [4:0]          r_p1, r_p2;
   logic                r_start;

   logic                w_fall, w_in_frame, w_stop_fall;
   logic                w_frame_ok, w_frame_err, w_timeout;
   logic [4:0]          w_p1_mask, w_p2_mask;

   // Lines idle high, so the conditioning chain resets to 1 to avoid a false edge.
   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         r_clk_meta   <= 1'b1;
         r_clk_sync   <= 1'b1;
         r_dat_meta   <= 1'b1;
         r_dat_sync   <= 1'b1;
         r_clk_filt   <= 1'b1;
         r_clk_filt_d <= 1'b1;
         r_filt_cnt   <= '0;
      end else begin
         r_clk_meta   <= ps2_clk;
         r_clk_sync   <= r_clk_meta;
         r_dat_meta   <= ps2_data;
         r_dat_sync   <= r_dat_meta;
         r_clk_filt_d <= r_clk_filt;
         if (r_clk_sync != r_clk_filt) begin
            if (r_filt_cnt == c_filt_last) begin
               r_clk_filt <= r_clk_sync;
               r_filt_cnt <= '0;
            end else begin
               r_filt_cnt <= r_filt_cnt + 1'b1;
            end
         end else begin
            r_filt_cnt <= '0;
         end
      end
   end

   assign w_fall      = r_clk_filt_d & ~r_clk_filt;
   assign w_in_frame  = (r_state != c_idle);
   assign w_stop_fall = w_fall & (r_state == c_stop);
   assign w_frame_ok  = r_dat_sync & (^{r_shift, r_parity});
   assign w_frame_err = w_stop_fall & ~w_frame_ok;
   assign w_timeout   = w_in_frame & ~w_fall & (r_tmo_cnt == c_tmo_last);

   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         r_state      <= c_idle;
         r_shift      <= '0;
         r_bit_cnt    <= '0;
         r_parity     <= 1'b0;
         r_tmo_cnt    <= '0;
         r_byte_valid <= 1'b0;
         r_byte       <= '0;
         r_rx_err     <= 1'b0;
      end else begin
         r_byte_valid <= 1'b0;
         r_rx_err     <= w_frame_err | w_timeout;
         if (!w_in_frame || w_fall) begin
            r_tmo_cnt <= '0;
         end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
         end
         if (w_timeout) begin
            r_state <= c_idle;
         end else if (w_fall) begin
            case (r_state)
               c_idle: begin
                  if (!r_dat_sync) begin
                     r_state   <= c_data;
                     r_bit_cnt <= '0;
                  end
               end
               c_data: begin
                  r_shift   <= {r_dat_sync, r_shift[7:1]};
                  r_bit_cnt <= r_bit_cnt + 3'd1;
                  if (r_bit_cnt == 3'd7) begin
                     r_state <= c_parity;
                  end
               end
               c_parity: begin
                  r_parity <= r_dat_sync;
                  r_state  <= c_stop;
               end
               c_stop: begin
                  r_state      <= c_idle;
                  r_byte_valid <= w_frame_ok;
                  r_byte       <= r_shift;
               end
               default: r_state <= c_idle;
            endcase
         end
      end
   end

   always_comb begin
      w_p1_mask = 5'b00000;
      w_p2_mask = 5'b00000;
      if (r_ext) begin
         case (r_byte)
            8'h75:   w_p1_mask = 5'b00001;
            8'h72:   w_p1_mask = 5'b00010;
            8'h6B:   w_p1_mask = 5'b00100;
            8'h74:   w_p1_mask = 5'b01000;
            8'h14:   w_p1_mask = 5'b10000;
            default: w_p1_mask = 5'b00000;
         endcase
      end else begin
         case (r_byte)
            8'h1D:   w_p2_mask = 5'b00001;
            8'h1B:   w_p2_mask = 5'b00010;
            8'h1C:   w_p2_mask = 5'b00100;
            8'h23:   w_p2_mask = 5'b01000;
            8'h29:   w_p2_mask = 5'b10000;
            default: w_p2_mask = 5'b00000;
         endcase
      end
   end

   // A bad or abandoned frame drops any pending prefix so the next key is read fresh.
   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         r_ext   <= 1'b0;
         r_brk   <= 1'b0;
         r_p1    <= '0;
         r_p2    <= '0;
         r_start <= 1'b0;
      end else begin
         r_start <= 1'b0;
         if (w_frame_err || w_timeout) begin
            r_ext <= 1'b0;
            r_brk <= 1'b0;
         end else if (r_byte_valid) begin
            if (r_byte == 8'hE0) begin
               r_ext <= 1'b1;
            end else if (r_byte == 8'hF0) begin
               r_brk <= 1'b1;
            end else begin
               r_ext   <= 1'b0;
               r_brk   <= 1'b0;
               r_p1    <= r_brk ? (r_p1 & ~w_p1_mask) : (r_p1 | w_p1_mask);
               r_p2    <= r_brk ? (r_p2 & ~w_p2_mask) : (r_p2 | w_p2_mask);
               r_start <= ~r_ext & ~r_brk & (r_byte == 8'h05);
            end
         end
      end
   end

   assign p1_control = r_p1;
   assign p2_control = r_p2;
   assign start      = r_start;
   assign rx_err     = r_rx_err;

endmodule
`default_nettype wire
